// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM: command codes and tx FSM states.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/spi_ram_tx_ctrl.sv
// Transmit-valid controller: holds tx_valid high for TX_HOLD cycles per start,
// restarting the hold whenever a new start arrives mid-send.
module spi_ram_tx_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned TX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic tx_valid
);

  localparam int unsigned CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TX_HOLD - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and hold-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a start always (re)loads the counter; otherwise count down in SEND.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_valid = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_SEND;
          cnt_d   = CNT_LOAD;
        end
      end
      TX_SEND: begin
        tx_valid = 1'b1;
        if (start) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/spi_ram.sv
// Single-port RAM driven by SPI slave words: decodes 2-bit commands for
// address/data writes and reads, returning read data with a held tx_valid.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned TX_HOLD   = 8,
  parameter int unsigned AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

  logic [7:0]           mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_set_q, rd_set_d;
  logic [7:0]           dout_q, dout_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 mem_we;
  logic                 rd_start;
  cmd_e                 cmd;

  assign cmd = cmd_e'(din[9:8]);

  // Command decode: one command per rx_valid cycle.
  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_set_d  = rd_set_q;
    dout_d    = dout_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;
    rd_start  = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
        CMD_WR_DATA: begin
          mem_we = 1'b1;
          if (AUTO_INC != 0) wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
        end
        CMD_RD_ADDR: begin
          rd_addr_d = din[ADDR_SIZE-1:0];
          rd_set_d  = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_set_q) begin
            dout_d   = mem[rd_addr_q];
            rd_start = 1'b1;
            if (AUTO_INC != 0) rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_set_q  <= 1'b0;
      dout_q    <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_set_q  <= rd_set_d;
      dout_q    <= dout_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Memory array: not reset, writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[wr_addr_q] <= din[7:0];
  end

  spi_ram_tx_ctrl #(
    .TX_HOLD(TX_HOLD)
  ) u_tx_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (rd_start),
    .tx_valid(tx_valid)
  );

  assign dout    = dout_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Self-checking bench for spi_ram with a behavioural memory/hold model.
module tb_spi_ram;

  localparam int unsigned ADDR_SIZE = 8;
  localparam int unsigned TX_HOLD   = 8;
  localparam int unsigned AUTO_INC  = 1;
  localparam int unsigned DEPTH     = 2 ** ADDR_SIZE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_mem [DEPTH];
  int         m_wr, m_rd, m_remain;
  bit         m_set, m_err;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  spi_ram #(
    .ADDR_SIZE(ADDR_SIZE),
    .TX_HOLD  (TX_HOLD),
    .AUTO_INC (AUTO_INC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .rx_valid(rx_valid),
    .dout    (dout),
    .tx_valid(tx_valid),
    .cmd_err (cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rstn, input bit rv, input logic [9:0] d);
    if (!rstn) begin
      m_wr = 0; m_rd = 0; m_set = 0; m_dout = '0; m_remain = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (m_remain > 0) m_remain--;
      if (rv) begin
        case (d[9:8])
          2'b00: m_wr = int'(d[7:0]) % DEPTH;
          2'b01: begin
            m_mem[m_wr] = d[7:0];
            if (AUTO_INC != 0) m_wr = (m_wr + 1) % DEPTH;
          end
          2'b10: begin
            m_rd  = int'(d[7:0]) % DEPTH;
            m_set = 1;
          end
          default: begin
            if (m_set) begin
              m_dout   = m_mem[m_rd];
              m_remain = TX_HOLD;
              if (AUTO_INC != 0) m_rd = (m_rd + 1) % DEPTH;
            end else begin
              m_err = 1;
            end
          end
        endcase
      end
    end
  endtask

  // One clock cycle: drive, let the edge happen, update model, check on the falling edge.
  task automatic cycle(input bit rstn, input bit rv, input logic [9:0] d);
    rst_n    = rstn;
    rx_valid = rv;
    din      = d;
    @(posedge clk);
    model_step(rstn, rv, d);
    @(negedge clk);
    chk("dout", {24'd0, dout}, {24'd0, m_dout});
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_remain > 0});
    chk("cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 10'h000);
  endtask

  initial begin
    int hi;

    // Reset with a read command present
    cycle(1'b0, 1'b1, 10'h3FF);
    cycle(1'b0, 1'b1, 10'h3FF);
    idle();
    chk("rst_dout", {24'd0, dout}, 32'h0);
    chk("rst_tx", {31'd0, tx_valid}, 32'h0);

    // Read data with no read address set
    cycle(1'b1, 1'b1, 10'h300);
    chk("err_pulse", {31'd0, cmd_err}, 32'h1);
    chk("err_tx", {31'd0, tx_valid}, 32'h0);
    idle();
    chk("err_clear", {31'd0, cmd_err}, 32'h0);

    // Fill the whole memory so every later read is defined
    cycle(1'b1, 1'b1, 10'h000);
    for (int unsigned i = 0; i < DEPTH; i++)
      cycle(1'b1, 1'b1, {2'b01, 8'($urandom)});

    // Basic write/read
    cycle(1'b1, 1'b1, 10'h010);
    cycle(1'b1, 1'b1, 10'h1A5);
    cycle(1'b1, 1'b1, 10'h210);
    cycle(1'b1, 1'b1, 10'h300);
    chk("basic_dout", {24'd0, dout}, 32'hA5);
    hi = int'(tx_valid);
    repeat (12) begin idle(); hi += int'(tx_valid); end
    chk("basic_hold", hi, TX_HOLD);

    // Back-to-back reads with auto-increment
    cycle(1'b1, 1'b1, 10'h020);
    cycle(1'b1, 1'b1, 10'h111);
    cycle(1'b1, 1'b1, 10'h122);
    cycle(1'b1, 1'b1, 10'h220);
    cycle(1'b1, 1'b1, 10'h300);
    chk("b2b_dout0", {24'd0, dout}, 32'h11);
    hi = int'(tx_valid);
    idle(); hi += int'(tx_valid);
    idle(); hi += int'(tx_valid);
    cycle(1'b1, 1'b1, 10'h300);
    chk("b2b_dout1", {24'd0, dout}, 32'h22);
    hi += int'(tx_valid);
    repeat (14) begin idle(); hi += int'(tx_valid); end
    chk("b2b_hold", hi, 3 + TX_HOLD);

    // Write-address wrap and reset in the middle of a send
    cycle(1'b1, 1'b1, 10'h0FF);
    cycle(1'b1, 1'b1, 10'h15A);
    cycle(1'b1, 1'b1, 10'h16B);
    cycle(1'b1, 1'b1, 10'h2FF);
    cycle(1'b1, 1'b1, 10'h300);
    chk("wrap_dout_ff", {24'd0, dout}, 32'h5A);
    idle(); idle(); idle();
    cycle(1'b0, 1'b0, 10'h000);
    chk("midrst_tx", {31'd0, tx_valid}, 32'h0);
    idle();
    chk("midrst_tx_rel", {31'd0, tx_valid}, 32'h0);
    cycle(1'b1, 1'b1, 10'h200);
    cycle(1'b1, 1'b1, 10'h300);
    chk("wrap_dout_00", {24'd0, dout}, 32'h6B);
    repeat (10) idle();

    // Write to the address being sent, mid-send
    cycle(1'b1, 1'b1, 10'h210);
    cycle(1'b1, 1'b1, 10'h300);
    chk("wds_dout", {24'd0, dout}, 32'hA5);
    cycle(1'b1, 1'b1, 10'h010);
    cycle(1'b1, 1'b1, 10'h177);
    chk("wds_tx", {31'd0, tx_valid}, 32'h1);
    repeat (8) idle();
    chk("wds_hold_dout", {24'd0, dout}, 32'hA5);
    cycle(1'b1, 1'b1, 10'h210);
    cycle(1'b1, 1'b1, 10'h300);
    chk("wds_new", {24'd0, dout}, 32'h77);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 10'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
